// File: rtl/comm_fpga_i2c_pkg.sv
// Shared encodings for the commFPGA I2C target.
package comm_fpga_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_BYTE  = 3'd3,
    WR_ACK   = 3'd4,
    RD_BYTE  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } i2c_state_e;

  localparam logic       ACK            = 1'b0;
  localparam logic       NAK            = 1'b1;
  localparam logic [7:0] UNDERFLOW_FILL = 8'hFF;

endpackage

// File: rtl/comm_fpga_i2c_slave_line_filter.sv
// Pad synchronizer, consecutive-sample glitch filter and edge pulses for one I2C line.
module i2c_line_filter #(
  parameter int GLITCH_CYCLES = 2
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic line_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  localparam logic [2:0] CNT_LAST = 3'(GLITCH_CYCLES - 1);

  logic [1:0] sync_q, sync_d;
  logic [2:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], line_in};
    filt_d = filt_q;
    cnt_d  = '0;
    prev_d = filt_q;
    // a new level must persist for GLITCH_CYCLES samples in a row
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) filt_d = sync_q[1];
      else                   cnt_d  = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
    end
  end

  assign level_out = filt_q;
  assign rise_out  = filt_q & ~prev_q;
  assign fall_out  = ~filt_q & prev_q;

endmodule

// File: rtl/comm_fpga_i2c_slave.sv
// I2C target answering a 7-bit address; writes go to an RX FIFO, reads come from a FWFT TX FIFO.
module comm_fpga_i2c_slave
  import comm_fpga_i2c_pkg::*;
#(
  parameter int GLITCH_CYCLES = 2
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe_out,
  input  logic [6:0] slave_addr_in,
  output logic [7:0] fifo_din_out,
  output logic       fifo_wr_out,
  input  logic       fifo_full_in,
  input  logic [7:0] fifo_dout_in,
  output logic       fifo_rd_out,
  input  logic       fifo_empty_in,
  output logic       busy_out,
  output logic       addressed_out,
  output logic       rw_out,
  output logic       overflow_out,
  output logic       underflow_out
);

  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;

  i2c_line_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_scl_filt (
    .clk_in(clk_in), .reset_in(reset_in), .line_in(scl_in),
    .level_out(scl), .rise_out(scl_rise), .fall_out(scl_fall)
  );

  i2c_line_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_sda_filt (
    .clk_in(clk_in), .reset_in(reset_in), .line_in(sda_in),
    .level_out(sda), .rise_out(sda_rise), .fall_out(sda_fall)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, tx_shift_q, tx_shift_d, din_q, din_d;
  logic [6:0] addr_q, addr_d;
  logic       phase_q, phase_d, nak_q, nak_d, oe_q, oe_d, wr_q, wr_d, rd_q, rd_d;
  logic       busy_q, busy_d, addressed_q, addressed_d, rw_q, rw_d;
  logic       ovf_q, ovf_d, unf_q, unf_d;
  logic       start_det, stop_det, byte_done, load_tx;
  logic [7:0] rx_byte, tx_next;

  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;
  assign rx_byte   = {shift_q[6:0], sda};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd7);
  assign tx_next   = fifo_empty_in ? UNDERFLOW_FILL : fifo_dout_in;

  always_comb begin
    state_d = state_q;   bit_cnt_d = bit_cnt_q; shift_d = shift_q;
    tx_shift_d = tx_shift_q; din_d = din_q;    addr_d = addr_q;
    phase_d = phase_q;   nak_d = nak_q;         oe_d = oe_q;
    busy_d = busy_q;     addressed_d = addressed_q; rw_d = rw_q;
    ovf_d = ovf_q;       unf_d = unf_q;
    wr_d = 1'b0;         rd_d = 1'b0;           load_tx = 1'b0;
    // bus conditions pre-empt any bit-level activity, discarding partial bytes
    if (start_det) begin
      state_d = ADDR; bit_cnt_d = '0; busy_d = 1'b1; oe_d = 1'b0;
      addressed_d = 1'b0; addr_d = slave_addr_in;
    end else if (stop_det) begin
      state_d = IDLE; busy_d = 1'b0; addressed_d = 1'b0; oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = byte_done ? 3'd0 : bit_cnt_q + 3'd1;
          if (byte_done) begin
            if (rx_byte[7:1] == addr_q) begin
              rw_d = rx_byte[0]; addressed_d = 1'b1; ovf_d = 1'b0; unf_d = 1'b0;
              phase_d = 1'b0; state_d = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            oe_d = 1'b1; phase_d = 1'b1;
          end else if (!rw_q) begin
            oe_d = 1'b0; bit_cnt_d = '0; state_d = WR_BYTE;
          end else begin
            load_tx = 1'b1;
          end
        end
        WR_BYTE: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = byte_done ? 3'd0 : bit_cnt_q + 3'd1;
          if (byte_done) begin
            phase_d = 1'b0; state_d = WR_ACK;
            if (!fifo_full_in) begin
              din_d = rx_byte; wr_d = 1'b1; nak_d = ACK;
            end else begin
              ovf_d = 1'b1; nak_d = NAK;
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            oe_d = (nak_q == ACK); phase_d = 1'b1;
          end else begin
            oe_d = 1'b0; bit_cnt_d = '0; state_d = WR_BYTE;
          end
        end
        // bit 7 went out on entry; seven more falls drive bits 6..0, the eighth releases
        RD_BYTE: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            oe_d = 1'b0; phase_d = 1'b0; state_d = RD_ACK;
          end else begin
            oe_d = ~tx_shift_q[7]; tx_shift_d = {tx_shift_q[6:0], 1'b1};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise && !phase_q) begin
            if (sda == NAK) state_d = IGNORE;
            else            phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            load_tx = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (load_tx) begin
      oe_d = ~tx_next[7]; tx_shift_d = {tx_next[6:0], 1'b1};
      bit_cnt_d = '0; state_d = RD_BYTE;
      if (fifo_empty_in) unf_d = 1'b1;
      else               rd_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;  bit_cnt_q <= '0;  shift_q <= '0;  tx_shift_q <= '0;
      din_q <= '0;      addr_q <= '0;     phase_q <= 1'b0; nak_q <= 1'b0;
      oe_q <= 1'b0;     wr_q <= 1'b0;     rd_q <= 1'b0;    busy_q <= 1'b0;
      addressed_q <= 1'b0; rw_q <= 1'b0;  ovf_q <= 1'b0;   unf_q <= 1'b0;
    end else begin
      state_q <= state_d;  bit_cnt_q <= bit_cnt_d;  shift_q <= shift_d;
      tx_shift_q <= tx_shift_d; din_q <= din_d;     addr_q <= addr_d;
      phase_q <= phase_d;  nak_q <= nak_d;          oe_q <= oe_d;
      wr_q <= wr_d;        rd_q <= rd_d;            busy_q <= busy_d;
      addressed_q <= addressed_d; rw_q <= rw_d;     ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign sda_oe_out    = oe_q;
  assign fifo_din_out  = din_q;
  assign fifo_wr_out   = wr_q;
  assign fifo_rd_out   = rd_q;
  assign busy_out      = busy_q;
  assign addressed_out = addressed_q;
  assign rw_out        = rw_q;
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;

endmodule

// File: tb/tb_comm_fpga_i2c_slave.sv
// Bit-banged I2C master against the target, checked by a transaction-level model of the bus.
module tb_comm_fpga_i2c_slave;

  localparam int Q = 10;

  logic       clk_in = 1'b0;
  logic       reset_in = 1'b1;
  logic       scl_in = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic       sda_oe_out;
  logic [6:0] slave_addr_in = 7'h42;
  logic [7:0] fifo_din_out;
  logic       fifo_wr_out;
  logic       fifo_full_in = 1'b0;
  logic [7:0] fifo_dout_in;
  logic       fifo_rd_out;
  logic       fifo_empty_in;
  logic       busy_out, addressed_out, rw_out, overflow_out, underflow_out;

  assign sda_in = sda_m & ~sda_oe_out;

  comm_fpga_i2c_slave dut (
    .clk_in(clk_in), .reset_in(reset_in), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe_out(sda_oe_out), .slave_addr_in(slave_addr_in),
    .fifo_din_out(fifo_din_out), .fifo_wr_out(fifo_wr_out), .fifo_full_in(fifo_full_in),
    .fifo_dout_in(fifo_dout_in), .fifo_rd_out(fifo_rd_out), .fifo_empty_in(fifo_empty_in),
    .busy_out(busy_out), .addressed_out(addressed_out), .rw_out(rw_out),
    .overflow_out(overflow_out), .underflow_out(underflow_out)
  );

  always #5 clk_in = ~clk_in;

  // TX FIFO environment (FWFT)
  logic [7:0] tx_mem [0:7];
  logic [3:0] tx_ptr = 4'd0;
  logic [3:0] tx_cnt = 4'd0;
  assign fifo_empty_in = (tx_ptr >= tx_cnt);
  assign fifo_dout_in  = tx_mem[tx_ptr[2:0]];
  always @(posedge clk_in) if (fifo_rd_out && (tx_ptr < tx_cnt)) tx_ptr <= tx_ptr + 4'd1;

  int n_cmp = 0;
  int n_fail = 0;

  // transaction-level model of what the target must do
  logic       m_sel = 1'b0, m_busy = 1'b0, m_addressed = 1'b0, m_rw = 1'b0;
  logic       m_ovf = 1'b0, m_unf = 1'b0;
  logic [7:0] exp_push [$];
  logic [7:0] m_tx [$];
  int         m_pops = 0, seen_pops = 0, seen_pushes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (!reset_in) begin
      if (fifo_wr_out) begin
        seen_pushes++;
        chk("push_expected", 32'(exp_push.size() > 0), 1);
        if (exp_push.size() > 0) chk("push_data", fifo_din_out, exp_push.pop_front());
      end
      if (fifo_rd_out) seen_pops++;
      if (fifo_wr_out || fifo_rd_out) chk("push_pop_exclusive", fifo_wr_out & fifo_rd_out, 0);
      if (!m_sel) chk("oe_while_unselected", sda_oe_out, 0);
    end
  end

  task automatic w(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic put_bit(input logic b, output logic seen);
    sda_m = b; w(Q); scl_in = 1'b1; w(Q); seen = sda_in; w(Q); scl_in = 1'b0; w(Q);
  endtask

  task automatic i2c_start();
    m_sel = 1'b0; m_addressed = 1'b0;
    sda_m = 1'b1; w(Q); scl_in = 1'b1; w(Q); sda_m = 1'b0; w(Q); scl_in = 1'b0; w(Q);
    m_busy = 1'b1;
  endtask

  task automatic i2c_stop();
    m_sel = 1'b0;
    sda_m = 1'b0; w(Q); scl_in = 1'b1; w(Q); sda_m = 1'b1; w(Q);
    m_busy = 1'b0; m_addressed = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic is_addr, output logic ack);
    logic exp_ack, s;
    if (is_addr) begin
      exp_ack = (b[7:1] == slave_addr_in) ? 1'b0 : 1'b1;
      if (!exp_ack) begin
        m_sel = 1'b1; m_addressed = 1'b1; m_rw = b[0]; m_ovf = 1'b0; m_unf = 1'b0;
      end
    end else begin
      exp_ack = !(m_sel && !fifo_full_in);
      if (m_sel && !fifo_full_in) exp_push.push_back(b);
      else if (m_sel)             m_ovf = 1'b1;
    end
    for (int i = 7; i >= 0; i--) put_bit(b[i], s);
    put_bit(1'b1, ack);
    chk(is_addr ? "addr_ack_slot" : "data_ack_slot", ack, exp_ack);
  endtask

  task automatic read_byte(input logic master_nak, output logic [7:0] d);
    logic [7:0] exp;
    logic s;
    if (m_tx.size() > 0) begin exp = m_tx.pop_front(); m_pops++; end
    else begin exp = 8'hFF; m_unf = 1'b1; end
    for (int i = 7; i >= 0; i--) begin put_bit(1'b1, s); d[i] = s; end
    put_bit(master_nak, s);
    if (master_nak) m_sel = 1'b0;
    chk("read_data", d, exp);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_busy"}, busy_out, m_busy);
    chk({tag, "_addressed"}, addressed_out, m_addressed);
    chk({tag, "_rw"}, rw_out, m_rw);
    chk({tag, "_overflow"}, overflow_out, m_ovf);
    chk({tag, "_underflow"}, underflow_out, m_unf);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_oe"}, sda_oe_out, 0);
    chk({tag, "_wr"}, fifo_wr_out, 0);
    chk({tag, "_rd"}, fifo_rd_out, 0);
    chk({tag, "_din"}, fifo_din_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_addressed"}, addressed_out, 0);
    chk({tag, "_rw"}, rw_out, 0);
    chk({tag, "_ovf"}, overflow_out, 0);
    chk({tag, "_unf"}, underflow_out, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, s;
    logic [7:0] d;
    logic [7:0] addr_w;

    w(4);
    check_all_zero("reset");
    reset_in = 1'b0;
    w(10);
    check_status("idle");

    // plain write of two bytes
    i2c_start();
    chk("busy_after_start", busy_out, 1);
    write_byte(8'h84, 1'b1, ack);
    chk("addr_0x84_acked", ack, 0);
    write_byte(8'hA5, 1'b0, ack);
    write_byte(8'h3C, 1'b0, ack);
    check_status("wr_mid");
    i2c_stop();
    check_status("wr_stop");
    chk("wr_push_count", seen_pushes, 2);

    // read two bytes, master NAKs the second
    tx_mem[0] = 8'h11; tx_mem[1] = 8'h22; tx_cnt = 4'd2;
    m_tx.push_back(8'h11); m_tx.push_back(8'h22);
    i2c_start();
    write_byte(8'h85, 1'b1, ack);
    read_byte(1'b0, d);
    chk("rd_first_literal", d, 8'h11);
    read_byte(1'b1, d);
    chk("rd_second_literal", d, 8'h22);
    check_status("rd_ignore");
    i2c_stop();
    check_status("rd_stop");
    chk("rd_pop_count", seen_pops, 2);

    // foreign address
    i2c_start();
    write_byte(8'h86, 1'b1, ack);
    chk("addr_0x86_naked", ack, 1);
    write_byte(8'h55, 1'b0, ack);
    check_status("foreign");
    i2c_stop();

    // RX FIFO full
    fifo_full_in = 1'b1;
    i2c_start();
    write_byte(8'h84, 1'b1, ack);
    write_byte(8'h77, 1'b0, ack);
    chk("full_byte_naked", ack, 1);
    i2c_stop();
    fifo_full_in = 1'b0;
    check_status("ovf_sticky");
    chk("ovf_literal", overflow_out, 1);

    // write then repeated start into an empty-FIFO read
    i2c_start();
    write_byte(8'h84, 1'b1, ack);
    check_status("ovf_cleared");
    write_byte(8'h01, 1'b0, ack);
    i2c_start();
    write_byte(8'h85, 1'b1, ack);
    chk("sr_addr_acked", ack, 0);
    read_byte(1'b1, d);
    chk("underflow_fill_literal", d, 8'hFF);
    check_status("unf_mid");
    i2c_stop();
    check_status("unf_stop");
    chk("unf_literal", underflow_out, 1);

    // asynchronous reset while the target holds the ACK
    addr_w = 8'h84;
    i2c_start();
    m_sel = 1'b1; m_addressed = 1'b1; m_rw = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int i = 7; i >= 0; i--) put_bit(addr_w[i], s);
    sda_m = 1'b1; w(Q); scl_in = 1'b1; w(Q / 2);
    chk("oe_before_reset", sda_oe_out, 1);
    #3 reset_in = 1'b1;
    #1 check_all_zero("async_reset");
    m_sel = 1'b0; m_busy = 1'b0; m_addressed = 1'b0; m_rw = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    w(3);
    reset_in = 1'b0;
    w(Q);
    scl_in = 1'b0; w(Q);
    write_byte(8'h84, 1'b0, ack);
    check_status("post_reset_ignored");
    i2c_start();
    write_byte(8'h84, 1'b1, ack);
    chk("post_reset_addr_acked", ack, 0);
    i2c_stop();
    check_status("final");

    chk("no_pending_pushes", exp_push.size(), 0);
    chk("pop_total", seen_pops, m_pops);
    chk("push_total_literal", seen_pushes, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
